// File: rtl/fault_injector.sv
// fault_injector: programmable, cycle-timed fault insertion on a WIDTH-bit bundle.
// A configuration handshake loads mask/mode/delay/duration; an IDLE/WAIT/INJECT/DONE
// FSM then corrupts the selected bits for exactly the programmed window.
// The data path itself is zero-latency: sig_out is combinational from sig_in.
module fault_injector #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] sig_out,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_duration,
    input  logic             abort,
    output logic             active,
    output logic             done,
    output logic [CNT_W-1:0] inject_cycles
);

    localparam logic [1:0] MODE_DRY = 2'b00;
    localparam logic [1:0] MODE_SA0 = 2'b01;
    localparam logic [1:0] MODE_SA1 = 2'b10;
    localparam logic [1:0] MODE_INV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WAIT   = 2'b01,
        S_INJECT = 2'b10,
        S_DONE   = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] delay_cnt_q, delay_cnt_d;
    logic [CNT_W-1:0] dur_cnt_q, dur_cnt_d;
    logic [CNT_W-1:0] inject_cycles_q, inject_cycles_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             accept;

    // Ready only decodes registered state; abort gating makes abort win over cfg_valid.
    assign cfg_ready = ((state_q == S_IDLE) || (state_q == S_DONE)) && !abort;
    assign accept    = cfg_valid && cfg_ready;

    assign active        = active_q;
    assign done          = done_q;
    assign inject_cycles = inject_cycles_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a duration counter of 0 never reaches 1, so the window is permanent.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state_d = (cfg_delay == '0) ? S_INJECT : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (delay_cnt_q == CNT_W'(1)) begin
                        state_d = S_INJECT;
                    end
                end
                S_INJECT: begin
                    if (dur_cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output and counter logic: config capture, delay/duration countdown, saturating inject count.
    always_comb begin
        mask_d          = mask_q;
        mode_d          = mode_q;
        delay_cnt_d     = delay_cnt_q;
        dur_cnt_d       = dur_cnt_q;
        inject_cycles_d = inject_cycles_q;
        if (accept) begin
            mask_d          = cfg_mask;
            mode_d          = cfg_mode;
            delay_cnt_d     = cfg_delay;
            dur_cnt_d       = cfg_duration;
            inject_cycles_d = '0;
        end else if (!abort) begin
            if (state_q == S_WAIT && delay_cnt_q != '0) begin
                delay_cnt_d = delay_cnt_q - CNT_W'(1);
            end
            if (state_q == S_INJECT) begin
                if (dur_cnt_q != '0) begin
                    dur_cnt_d = dur_cnt_q - CNT_W'(1);
                end
                if (inject_cycles_q != {CNT_W{1'b1}}) begin
                    inject_cycles_d = inject_cycles_q + CNT_W'(1);
                end
            end
        end
        active_d = (state_d == S_INJECT);
        done_d   = (state_d == S_DONE);
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q          <= '0;
            mode_q          <= MODE_DRY;
            delay_cnt_q     <= '0;
            dur_cnt_q       <= '0;
            inject_cycles_q <= '0;
            active_q        <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            mask_q          <= mask_d;
            mode_q          <= mode_d;
            delay_cnt_q     <= delay_cnt_d;
            dur_cnt_q       <= dur_cnt_d;
            inject_cycles_q <= inject_cycles_d;
            active_q        <= active_d;
            done_q          <= done_d;
        end
    end

    // Zero-latency fault application; active_q clears asynchronously on reset, so sig_out goes clean at once.
    always_comb begin
        sig_out = sig_in;
        if (active_q) begin
            case (mode_q)
                MODE_SA0: sig_out = sig_in & ~mask_q;
                MODE_SA1: sig_out = sig_in | mask_q;
                MODE_INV: sig_out = sig_in ^ mask_q;
                default:  sig_out = sig_in;
            endcase
        end
    end

endmodule

// File: tb/tb_fault_injector.sv
// tb_fault_injector: scoreboard bench; expected per-cycle outputs are derived from the
// accept-relative timing formulas and popped/compared on the falling edge.
module tb_fault_injector;

    typedef struct {
        logic [7:0]  sig;
        logic        act;
        logic        dn;
        logic [15:0] ic;
        logic        rdy;
        logic        chk_ic;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  sig_in, sig_out;
    logic        cfg_valid, cfg_ready;
    logic [7:0]  cfg_mask;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_delay, cfg_duration;
    logic        abort, active, done;
    logic [15:0] inject_cycles;

    logic [3:0]  s_sig_in, s_sig_out, s_mask;
    logic        s_valid, s_ready, s_abort, s_active, s_done;
    logic [1:0]  s_mode, s_delay, s_duration, s_ic;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fault_injector #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .sig_out(sig_out),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mask(cfg_mask),
        .cfg_mode(cfg_mode), .cfg_delay(cfg_delay), .cfg_duration(cfg_duration),
        .abort(abort), .active(active), .done(done), .inject_cycles(inject_cycles)
    );

    fault_injector #(.WIDTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .sig_in(s_sig_in), .sig_out(s_sig_out),
        .cfg_valid(s_valid), .cfg_ready(s_ready), .cfg_mask(s_mask),
        .cfg_mode(s_mode), .cfg_delay(s_delay), .cfg_duration(s_duration),
        .abort(s_abort), .active(s_active), .done(s_done), .inject_cycles(s_ic)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] fault_val(input logic [7:0] s, input logic [7:0] m,
                                             input logic [1:0] md);
        case (md)
            2'b01:   return s & ~m;
            2'b10:   return s | m;
            2'b11:   return s ^ m;
            default: return s;
        endcase
    endfunction

    // Expected outputs in cycle n after the accepting edge (abort low).
    function automatic exp_t camp_exp(input int n, input logic [7:0] s, input logic [7:0] m,
                                      input logic [1:0] md, input int d, input int du);
        exp_t e;
        bit   win;
        int   ic;
        win = (n >= d + 1) && (du == 0 || n <= d + du);
        if (n <= d) ic = 0;
        else begin
            ic = n - d - 1;
            if (du != 0 && ic > du) ic = du;
        end
        e.act    = win;
        e.dn     = (du != 0) && (n >= d + du + 1);
        e.rdy    = e.dn;
        e.ic     = 16'(ic);
        e.chk_ic = 1'b1;
        e.sig    = win ? fault_val(s, m, md) : s;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] m, input logic [1:0] md, input int d, input int du,
                         input logic [7:0] s);
        tick();
        cfg_mask     = m;
        cfg_mode     = md;
        cfg_delay    = 16'(d);
        cfg_duration = 16'(du);
        cfg_valid    = 1'b1;
        abort        = 1'b0;
        sig_in       = s;
    endtask

    task automatic run_cycles(input int n_from, input int n_to, input logic [7:0] m,
                              input logic [1:0] md, input int d, input int du,
                              input logic [7:0] s, input bit rnd);
        for (int n = n_from; n <= n_to; n++) begin
            tick();
            cfg_valid = 1'b0;
            abort     = 1'b0;
            sig_in    = rnd ? 8'($urandom) : s;
            sb.push_back(camp_exp(n, sig_in, m, md, d, du));
        end
    endtask

    task automatic idle(input int k, input logic [7:0] s, input int ic);
        exp_t e;
        for (int i = 0; i < k; i++) begin
            tick();
            cfg_valid = 1'b0;
            abort     = 1'b0;
            sig_in    = s;
            e.sig = s; e.act = 1'b0; e.dn = 1'b0; e.ic = 16'(ic); e.rdy = 1'b1; e.chk_ic = 1'b1;
            sb.push_back(e);
        end
    endtask

    // Scoreboard monitor: compare one expectation per cycle, mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("sig_out", 32'(sig_out), 32'(mon_e.sig));
            chk("active", 32'(active), 32'(mon_e.act));
            chk("done", 32'(done), 32'(mon_e.dn));
            chk("cfg_ready", 32'(cfg_ready), 32'(mon_e.rdy));
            if (mon_e.chk_ic) chk("inject_cycles", 32'(inject_cycles), 32'(mon_e.ic));
        end
    end

    initial begin
        logic [7:0] rm;
        logic [1:0] rmd;
        exp_t e;

        rst_n = 1'b0; sig_in = 8'h3C; cfg_valid = 1'b0; cfg_mask = '0; cfg_mode = '0;
        cfg_delay = '0; cfg_duration = '0; abort = 1'b0;
        s_sig_in = 4'h5; s_valid = 1'b0; s_mask = '0; s_mode = '0; s_delay = '0;
        s_duration = '0; s_abort = 1'b0;

        #2;
        chk("rst_sig_out", 32'(sig_out), 32'h3C);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ic", 32'(inject_cycles), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2, 8'h3C, 0);

        // Stuck-at-1 on low nibble, delay 3, duration 2.
        offer(8'h0F, 2'b10, 3, 2, 8'h00);
        run_cycles(1, 8, 8'h0F, 2'b10, 3, 2, 8'h00, 1'b0);

        // Random mask/mode with sig_in changing every cycle (zero-latency path), accepted from DONE.
        rm  = 8'($urandom);
        rmd = 2'($urandom_range(0, 3));
        offer(rm, rmd, 2, 3, 8'($urandom));
        run_cycles(1, 8, rm, rmd, 2, 3, 8'h00, 1'b1);

        // Invert, delay 0, duration 1: single faulted cycle.
        offer(8'h81, 2'b11, 0, 1, 8'h55);
        run_cycles(1, 3, 8'h81, 2'b11, 0, 1, 8'h55, 1'b0);

        // Permanent stuck-at-0 until abort in cycle 20.
        offer(8'hFF, 2'b01, 0, 0, 8'hFF);
        run_cycles(1, 19, 8'hFF, 2'b01, 0, 0, 8'hFF, 1'b0);
        tick();
        abort = 1'b1;
        e = camp_exp(20, 8'hFF, 8'hFF, 2'b01, 0, 0);
        sb.push_back(e);
        idle(2, 8'hFF, 19);

        // Abort and cfg_valid together in DONE: abort wins, nothing accepted.
        offer(8'hFF, 2'b01, 1, 1, 8'h33);
        run_cycles(1, 3, 8'hFF, 2'b01, 1, 1, 8'h33, 1'b0);
        tick();
        cfg_valid = 1'b1; abort = 1'b1; cfg_mask = 8'hFF; cfg_mode = 2'b01;
        cfg_delay = 16'd1; cfg_duration = 16'd1;
        e.sig = 8'h33; e.act = 1'b0; e.dn = 1'b1; e.ic = 16'd1; e.rdy = 1'b0; e.chk_ic = 1'b1;
        sb.push_back(e);
        idle(3, 8'h33, 1);

        // cfg_valid during WAIT must be ignored; original window still applies.
        offer(8'hF0, 2'b10, 4, 2, 8'h0A);
        run_cycles(1, 1, 8'hF0, 2'b10, 4, 2, 8'h0A, 1'b0);
        tick();
        cfg_valid = 1'b1; cfg_mask = 8'hFF; cfg_mode = 2'b11; cfg_delay = 16'd0;
        cfg_duration = 16'd5; sig_in = 8'h0A;
        sb.push_back(camp_exp(2, 8'h0A, 8'hF0, 2'b10, 4, 2));
        run_cycles(3, 8, 8'hF0, 2'b10, 4, 2, 8'h0A, 1'b0);

        // Asynchronous reset in the middle of a permanent injection.
        offer(8'hFF, 2'b10, 0, 0, 8'h00);
        run_cycles(1, 3, 8'hFF, 2'b10, 0, 0, 8'h00, 1'b0);
        @(posedge clk); #3;
        rst_n  = 1'b0;
        sig_in = 8'hA5;
        #1;
        chk("arst_sig_out", 32'(sig_out), 32'hA5);
        chk("arst_active", 32'(active), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_ic", 32'(inject_cycles), 32'd0);
        chk("arst_ready", 32'(cfg_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        idle(3, 8'hA5, 0);

        // Saturation of a 2-bit inject counter over 10 permanent INJECT cycles.
        tick();
        s_valid = 1'b1; s_mask = 4'hF; s_mode = 2'b11; s_delay = 2'd0; s_duration = 2'd0;
        tick();
        s_valid = 1'b0;
        tick(); tick();
        chk("sat_ic_c3", 32'(s_ic), 32'd2);
        repeat (8) tick();
        chk("sat_ic_c11", 32'(s_ic), 32'd3);
        chk("sat_active", 32'(s_active), 32'd1);
        chk("sat_sig_out", 32'(s_sig_out), 32'hA);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
